// File: rtl/bsk_prm_pkg.sv
// Shared types and constants for the command parameter generator.
// Holds the enable FSM encoding, control codes and bus address map.
package bsk_prm_pkg;

    typedef enum logic [1:0] {
        StLocked  = 2'b00,
        StArmed   = 2'b01,
        StEnabled = 2'b10
    } en_state_e;

    localparam logic [7:0] CodeArm    = 8'h5A;
    localparam logic [7:0] CodeEnable = 8'hE1;

    localparam logic [3:0] AddrComTBase  = 4'd0;
    localparam logic [3:0] AddrComRdBase = 4'd4;
    localparam logic [3:0] AddrComIndBase = 4'd8;
    localparam logic [3:0] AddrStatus    = 4'd14;
    localparam logic [3:0] AddrCtrl      = 4'd15;

    // Each data nibble is written together with its bitwise complement.
    function automatic logic nib_bad(input logic [3:0] data, input logic [3:0] check);
        return data != ~check;
    endfunction

endpackage

// File: rtl/bsk_bus_sync.sv
// Brings the asynchronous write bus into the clock domain and produces a one-cycle
// commit strobe on the clock after the synchronised write strobe rises.
module bsk_bus_sync (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_ni,
    input  logic        bl_ni,
    input  logic [3:0]  a_i,
    input  logic [3:0]  cs_i,
    input  logic [15:0] d_i,
    output logic        bl_o,
    output logic        commit_o,
    output logic [3:0]  a_o,
    output logic [3:0]  cs_o,
    output logic [15:0] d_o
);

    // wr_q[1:0] is the synchroniser, wr_q[2] the previous synced value for edge detect.
    logic [2:0]  wr_q;
    logic [1:0]  bl_q;
    logic [3:0]  a_s1_q, a_s2_q, a_smp_q;
    logic [3:0]  cs_s1_q, cs_s2_q, cs_smp_q;
    logic [15:0] d_s1_q, d_s2_q, d_smp_q;

    // Active-low strobes clear to their idle (high) level so reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q     <= '1;
            bl_q     <= '1;
            a_s1_q   <= '0;
            a_s2_q   <= '0;
            a_smp_q  <= '0;
            cs_s1_q  <= '0;
            cs_s2_q  <= '0;
            cs_smp_q <= '0;
            d_s1_q   <= '0;
            d_s2_q   <= '0;
            d_smp_q  <= '0;
        end else begin
            wr_q    <= {wr_q[1:0], wr_ni};
            bl_q    <= {bl_q[0], bl_ni};
            a_s1_q  <= a_i;
            a_s2_q  <= a_s1_q;
            cs_s1_q <= cs_i;
            cs_s2_q <= cs_s1_q;
            d_s1_q  <= d_i;
            d_s2_q  <= d_s1_q;
            if (!wr_q[1]) begin
                a_smp_q  <= a_s2_q;
                cs_smp_q <= cs_s2_q;
                d_smp_q  <= d_s2_q;
            end
        end
    end

    assign commit_o = wr_q[1] & ~wr_q[2];
    assign bl_o     = ~bl_q[1];
    assign a_o      = a_smp_q;
    assign cs_o     = cs_smp_q;
    assign d_o      = d_smp_q;

endmodule

// File: rtl/bsk_prm_gen.sv
// Command parameter generator: bus-written command groups with complement checking,
// enable FSM and status readback. Define BSK_PRM_GEN_WD_EN to build the watchdog.
module bsk_prm_gen
    import bsk_prm_pkg::*;
#(
    parameter logic [5:0]  VERSION    = 6'h25,
    parameter logic [7:0]  PASSWORD   = 8'hA6,
    parameter logic [3:0]  CS         = 4'b0111,
    parameter int unsigned NUM_GROUPS = 2,
    parameter int unsigned WD_CYCLES  = 100000
) (
    input  logic                      iClk,
    input  logic                      iRes,
    inout  wire  [15:0]               bD,
    input  logic                      iRd,
    input  logic                      iWr,
    input  logic [3:0]                iA,
    input  logic [3:0]                iCS,
    input  logic                      iBl,
    input  logic                      iKEnable,
    input  logic [16*NUM_GROUPS-1:0]  iComT,
    output logic [16*NUM_GROUPS-1:0]  oCom,
    output logic [16*NUM_GROUPS-1:0]  oComInd,
    output logic                      oCS,
    output logic                      oEnable
);

    logic        bl, commit, wr_ok, com_wr, ctrl_wr, wd_exp;
    logic [3:0]  wa, wcs;
    logic [15:0] wdat;
    logic [1:0]  nib_err;
    logic [7:0]  com_byte;
    logic [15:0] rd_data;

    logic [NUM_GROUPS-1:0][15:0] com_q, com_d;
    logic [NUM_GROUPS-1:0][3:0]  err_q, err_d;
    logic [NUM_GROUPS-1:0][15:0] com_ind_q, com_ind_d;
    en_state_e                   state_q;

    bsk_bus_sync u_sync (
        .clk_i    (iClk),
        .rst_i    (iRes),
        .wr_ni    (iWr),
        .bl_ni    (iBl),
        .a_i      (iA),
        .cs_i     (iCS),
        .d_i      (bD),
        .bl_o     (bl),
        .commit_o (commit),
        .a_o      (wa),
        .cs_o     (wcs),
        .d_o      (wdat)
    );

    assign wr_ok    = commit && (wcs == CS);
    assign com_wr   = wr_ok && (32'(wa) < 2 * NUM_GROUPS);
    assign ctrl_wr  = wr_ok && (wa == AddrCtrl);
    assign nib_err  = {nib_bad(wdat[11:8], wdat[15:12]), nib_bad(wdat[3:0], wdat[7:4])};
    assign com_byte = {wdat[15:12], wdat[7:4]};

    always_comb begin
        com_d     = com_q;
        err_d     = err_q;
        com_ind_d = com_ind_q;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (com_wr && wa == 4'(2 * g)) begin
                com_d[g][7:0] = com_byte;
                err_d[g][1:0] = nib_err;
            end
            if (com_wr && wa == 4'(2 * g + 1)) begin
                com_d[g][15:8] = com_byte;
                err_d[g][3:2]  = nib_err;
            end
            if (wr_ok && wa == AddrComIndBase + 4'(g)) begin
                com_ind_d[g] = wdat;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRes) begin
            com_q     <= '0;
            err_q     <= '1;
            com_ind_q <= '0;
        end else begin
            com_q     <= com_d;
            err_q     <= err_d;
            com_ind_q <= com_ind_d;
        end
    end

    // Block input overrides any control write landing in the same cycle.
    always_ff @(posedge iClk) begin
        if (iRes || bl) begin
            state_q <= StLocked;
        end else if (ctrl_wr) begin
            if (wdat[7:0] == CodeArm) begin
                state_q <= StArmed;
            end else if (wdat[7:0] == CodeEnable && state_q == StArmed) begin
                state_q <= StEnabled;
            end else begin
                state_q <= StLocked;
            end
        end
    end

`ifdef BSK_PRM_GEN_WD_EN
    localparam int unsigned WdW = $clog2(WD_CYCLES + 1);
    localparam logic [WdW-1:0] WdLoad = WdW'(WD_CYCLES);
    localparam logic [WdW-1:0] WdOne  = WdW'(1);

    logic [WdW-1:0] wd_cnt_q;
    logic           wd_exp_q;
    logic           wd_reload;

    assign wd_reload = com_wr && (nib_err == 2'b00);

    always_ff @(posedge iClk) begin
        if (iRes || wd_reload) begin
            wd_cnt_q <= WdLoad;
            wd_exp_q <= 1'b0;
        end else if (wd_cnt_q != '0) begin
            wd_cnt_q <= wd_cnt_q - WdOne;
            if (wd_cnt_q == WdOne) begin
                wd_exp_q <= 1'b1;
            end
        end
    end

    assign wd_exp = wd_exp_q;
`else
    assign wd_exp = 1'b0;
`endif

    always_comb begin
        oCom = '1;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (!(iRes || bl || wd_exp || (|err_q[g]))) begin
                oCom[16*g +: 16] = com_q[g];
            end
        end
    end

    assign oComInd = iRes ? '1 : ~com_ind_q;
    assign oEnable = iRes || !(state_q == StEnabled && !bl);
    assign oCS     = !(iCS == CS);

    always_comb begin
        rd_data = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (iA == AddrComTBase + 4'(g)) begin
                rd_data = iComT[16*g +: 16];
            end
            if (iA == AddrComRdBase + 4'(g)) begin
                rd_data = com_q[g];
            end
        end
        if (iA == AddrStatus) begin
            rd_data = {12'b0, bl, wd_exp, state_q};
        end
        if (iA == AddrCtrl) begin
            rd_data = {PASSWORD, VERSION, iKEnable, state_q == StEnabled};
        end
    end

    assign bD = (!iRd && iCS == CS) ? rd_data : 16'bz;

endmodule

// File: tb/tb_bsk_prm_gen.sv
// Scoreboard bench for bsk_prm_gen: stimulus queues expected values, a negedge
// monitor pops and compares them. Watchdog checks depend on BSK_PRM_GEN_WD_EN.
module tb_bsk_prm_gen;

    localparam logic [3:0]  CS = 4'b0111;
    localparam int unsigned NG = 2;
    localparam int unsigned WD = 16;

    logic                iClk, iRes, iRd, iWr, iBl, iKEnable, oCS, oEnable;
    logic [3:0]          iA, iCS;
    logic [16*NG-1:0]    iComT, oCom, oComInd;
    wire  [15:0]         bD;
    logic [15:0]         d_drv;
    logic                d_en;

    assign bD = d_en ? d_drv : 16'bz;

    bsk_prm_gen #(
        .NUM_GROUPS (NG),
        .WD_CYCLES  (WD)
    ) dut (
        .iClk     (iClk),
        .iRes     (iRes),
        .bD       (bD),
        .iRd      (iRd),
        .iWr      (iWr),
        .iA       (iA),
        .iCS      (iCS),
        .iBl      (iBl),
        .iKEnable (iKEnable),
        .iComT    (iComT),
        .oCom     (oCom),
        .oComInd  (oComInd),
        .oCS      (oCS),
        .oEnable  (oEnable)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int          total = 0;
    int          bad = 0;
    string       nq[$];
    int          sq[$];
    logic [31:0] eq[$];

    // Independent watchdog model; a valid com write reloads on its commit edge.
    int unsigned ecnt = 0;
    int unsigned reload_at = 0;
    int unsigned m_cnt = WD;
    bit          m_exp = 1'b0;

    initial forever begin
        @(posedge iClk);
        ecnt++;
        if (iRes || ecnt == reload_at) begin
            m_cnt = WD;
            m_exp = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) m_exp = 1'b1;
        end
    end

    function automatic bit wexp();
`ifdef BSK_PRM_GEN_WD_EN
        return m_exp;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ocom_exp(input logic [31:0] v);
        return wexp() ? 32'hFFFF_FFFF : v;
    endfunction

    function automatic logic [31:0] st14(input logic b, input logic [1:0] s);
        return {28'b0, b, wexp(), s};
    endfunction

    initial forever begin
        string       n;
        int          s;
        logic [31:0] e, a;
        @(negedge iClk);
        if (eq.size() != 0) begin
            n = nq.pop_front();
            s = sq.pop_front();
            e = eq.pop_front();
            case (s)
                0:       a = oCom;
                1:       a = oComInd;
                2:       a = {31'b0, oEnable};
                3:       a = {16'b0, bD};
                default: a = {31'b0, oCS};
            endcase
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got %h want %h", n, a, e);
            end
        end
    end

    task automatic clk(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic check(input string n, input int s, input logic [31:0] e);
        nq.push_back(n);
        sq.push_back(s);
        eq.push_back(e);
        @(negedge iClk);
        #1;
        if (eq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: pending=%0d want 0", n, eq.size());
            nq.delete();
            sq.delete();
            eq.delete();
        end
    endtask

    task automatic rd(input string n, input logic [3:0] a, input logic [15:0] e);
        iA  = a;
        iRd = 1'b0;
        check(n, 3, {16'b0, e});
        iRd = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [3:0] cs = CS);
        bit ok;
        ok = (cs == CS) && (a < 4'(2 * NG)) && (d[3:0] == ~d[7:4]) && (d[11:8] == ~d[15:12]);
        iA    = a;
        iCS   = cs;
        d_drv = d;
        d_en  = 1'b1;
        iWr   = 1'b0;
        clk(4);
        iWr = 1'b1;
        if (ok) reload_at = ecnt + 3;
        clk(3);
        d_en = 1'b0;
        iCS  = CS;
    endtask

    initial begin
        iRes = 1'b1; iWr = 1'b1; iRd = 1'b1; iBl = 1'b1; iKEnable = 1'b1;
        iCS = CS; iA = 4'd0; iComT = 32'hDEAD_BEEF; d_drv = 16'h0; d_en = 1'b0;
        clk(3);
        check("rst_ocom", 0, 32'hFFFF_FFFF);
        check("rst_ocomind", 1, 32'hFFFF_FFFF);
        check("rst_oen", 2, 32'h1);
        iRes = 1'b0;
        clk(1);
        check("ocs_sel", 4, 32'h0);
        iCS = 4'h0;
        check("ocs_desel", 4, 32'h1);
        iCS = CS;
        rd("rd_comt0", 4'd0, 16'hBEEF);
        rd("rd_comt1", 4'd1, 16'hDEAD);
        rd("rd_id_locked", 4'd15, 16'hA696);
        rd("rd_st_reset", 4'd14, st14(1'b0, 2'b00));

        // Command groups: low/high byte writes with nibble complements
        wr(4'd0, 16'hA55A);
        rd("rd_com0_lo", 4'd4, 16'h00A5);
        check("grp0_half", 0, ocom_exp(32'hFFFF_FFFF));
        wr(4'd1, 16'h3CC3);
        check("grp0_ok", 0, ocom_exp(32'hFFFF_3CA5));
        wr(4'd2, 16'h9669);
        wr(4'd3, 16'h1EE1);
        check("grp01_ok", 0, ocom_exp(32'h1E96_3CA5));
        wr(4'd1, 16'h00F0);
        check("grp0_bad", 0, ocom_exp(32'h1E96_FFFF));
        rd("rd_com0_bad", 4'd4, 16'h0FA5);
        rd("rd_com1", 4'd5, 16'h1E96);

        // Indication registers, chip-select and address filtering
        wr(4'd8, 16'h1234);
        wr(4'd9, 16'h00FF);
        check("comind", 1, 32'hFF00_EDCB);
        wr(4'd8, 16'hFFFF, 4'h0);
        check("comind_badcs", 1, 32'hFF00_EDCB);
        wr(4'd10, 16'h5555);
        check("comind_unmapped", 1, 32'hFF00_EDCB);
        rd("rd_unmapped", 4'd6, 16'h0000);

        // Enable FSM
        wr(4'd15, 16'h005A);
        rd("st_armed", 4'd14, st14(1'b0, 2'b01));
        wr(4'd15, 16'h00E1);
        check("oen_enabled", 2, 32'h0);
        rd("st_enabled", 4'd14, st14(1'b0, 2'b10));
        rd("rd_id_en", 4'd15, 16'hA697);
        wr(4'd15, 16'h005A);
        wr(4'd15, 16'h0033);
        rd("st_locked", 4'd14, st14(1'b0, 2'b00));
        check("oen_locked", 2, 32'h1);
        wr(4'd15, 16'h00E1);
        rd("st_e1_from_locked", 4'd14, st14(1'b0, 2'b00));

        // Block input
        wr(4'd15, 16'h005A);
        wr(4'd15, 16'h00E1);
        check("oen_reenabled", 2, 32'h0);
        iBl = 1'b0;
        clk(2);
        check("bl_oen", 2, 32'h1);
        check("bl_ocom", 0, 32'hFFFF_FFFF);
        clk(1);
        rd("bl_st", 4'd14, st14(1'b1, 2'b00));
        iBl = 1'b1;
        clk(3);
        rd("bl_released", 4'd14, st14(1'b0, 2'b00));
        wr(4'd1, 16'h3CC3);
        check("grp_restore", 0, ocom_exp(32'h1E96_3CA5));

        // Watchdog: the restore write reloaded it on its commit edge
        clk(15);
`ifdef BSK_PRM_GEN_WD_EN
        rd("wd_before", 4'd14, 16'h0000);
        clk(1);
        rd("wd_expired", 4'd14, 16'h0004);
        check("wd_ocom", 0, 32'hFFFF_FFFF);
        wr(4'd0, 16'hA55A);
        check("wd_cleared", 0, 32'h1E96_3CA5);
        rd("wd_cleared_st", 4'd14, 16'h0000);
`else
        clk(1);
        rd("wd_off_st", 4'd14, 16'h0000);
        check("wd_off_ocom", 0, 32'h1E96_3CA5);
`endif

        // Reset in the middle of a write discards it
        iA = 4'd8; iCS = CS; d_drv = 16'hAAAA; d_en = 1'b1; iWr = 1'b0;
        clk(3);
        iRes = 1'b1;
        clk(1);
        check("rstw_ocom", 0, 32'hFFFF_FFFF);
        check("rstw_ocomind", 1, 32'hFFFF_FFFF);
        check("rstw_oen", 2, 32'h1);
        iWr = 1'b1;
        clk(4);
        iRes = 1'b0;
        d_en = 1'b0;
        clk(6);
        check("rstw_discard", 1, 32'hFFFF_FFFF);
        rd("rstw_com0", 4'd4, 16'h0000);
        rd("rstw_st", 4'd14, st14(1'b0, 2'b00));
        check("rstw_ocom_post", 0, 32'hFFFF_FFFF);

        clk(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
